hazard_forward_unit: RTL and testbench

//  Combined forwarding and load-use hazard unit for the 5-stage pipeline.
//  - Forwards EX/EX, MEM/EX and MEM/MEM operands, with generic widths.
//  - A load-use FSM inserts a configurable number of bubbles between a load in EX and its consumer in ID.
//  - Exposes optional hazard performance counters.

---
 rtl/hazard_forward_unit.sv | 134 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Operand forwarding (EX/EX, MEM/EX, MEM/MEM) and load-use bubble insertion for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to build the live stall/forward performance counters; otherwise they read 0.
module hazard_forward_unit #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1_addr,
    input  logic [AW-1:0]    id_rs2_addr,
    input  logic             id_memwrite,
    input  logic             flush,
    input  logic [AW-1:0]    ex_rs1_addr,
    input  logic [AW-1:0]    ex_rs2_addr,
    input  logic [XLEN-1:0]  ex_rs1_v,
    input  logic [XLEN-1:0]  ex_rs2_v,
    input  logic [AW-1:0]    ex_rd_addr,
    input  logic             ex_memread,
    input  logic             mem_regwrite,
    input  logic [AW-1:0]    mem_rd_addr,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [AW-1:0]    mem_rs2_addr,
    input  logic [XLEN-1:0]  mem_rs2_v,
    input  logic             wb_regwrite,
    input  logic [AW-1:0]    wb_rd_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  fwd_rs1,
    output logic [XLEN-1:0]  fwd_rs2,
    output logic [XLEN-1:0]  fwd_m_wdata,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    typedef enum logic {IDLE, STALL} state_t;

    // The Mealy cycle in IDLE is the first bubble, so STALL only covers the remaining LOAD_LAT-1.
    localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       stall_raw;
    logic       hz;
    logic       mem_hit1, mem_hit2, wb_hit1, wb_hit2, hit1, hit2, wb_hit_m;

    assign mem_hit1 = mem_regwrite && (mem_rd_addr == ex_rs1_addr) && (ex_rs1_addr != '0);
    assign mem_hit2 = mem_regwrite && (mem_rd_addr == ex_rs2_addr) && (ex_rs2_addr != '0);
    assign wb_hit1  = wb_regwrite  && (wb_rd_addr  == ex_rs1_addr) && (ex_rs1_addr != '0);
    assign wb_hit2  = wb_regwrite  && (wb_rd_addr  == ex_rs2_addr) && (ex_rs2_addr != '0);
    assign wb_hit_m = wb_regwrite  && (wb_rd_addr  == mem_rs2_addr) && (mem_rs2_addr != '0);
    assign hit1     = mem_hit1 | wb_hit1;
    assign hit2     = mem_hit2 | wb_hit2;

    assign fwd_rs1     = mem_hit1 ? mem_alu_result : (wb_hit1 ? wb_data : ex_rs1_v);
    assign fwd_rs2     = mem_hit2 ? mem_alu_result : (wb_hit2 ? wb_data : ex_rs2_v);
    assign fwd_m_wdata = wb_hit_m ? wb_data : mem_rs2_v;

    // A store needing the load result only as store data is served by MEM/MEM forwarding.
    assign hz = id_valid && ex_memread && (ex_rd_addr != '0) &&
                ((ex_rd_addr == id_rs1_addr) ||
                 ((ex_rd_addr == id_rs2_addr) && !id_memwrite));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_raw = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz) begin
                        stall_raw = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_raw = 1'b1;
                    if (cnt == 2'd0) state_nxt = IDLE;
                    else             cnt_nxt   = cnt - 2'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Reset also masks the Mealy path so the stall drops the moment rst_n falls.
    assign stall_if_id = stall_raw & rst_n;
    assign bubble_ex   = stall_raw & rst_n;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, fwd_q;
    logic [1:0]       fwd_inc;
    logic [CNT_W:0]   fwd_sum;

    assign fwd_inc = {1'b0, hit1} + {1'b0, hit2};
    assign fwd_sum = {1'b0, fwd_q} + {{(CNT_W-1){1'b0}}, fwd_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            fwd_q   <= '0;
        end else begin
            if (stall_if_id && !(&stall_q)) stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
            fwd_q <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
        end
    end

    assign stall_cnt = stall_q;
    assign fwd_cnt   = fwd_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: vector table, hand-written stall/flush/reset sequences, random run vs reference model.
module tb_hazard_forward_unit;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CW1  = 4;
    localparam int CW3  = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            id_valid, id_memwrite, flush, ex_memread, mem_regwrite, wb_regwrite;
    logic [AW-1:0]   id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [AW-1:0]   mem_rd_addr, mem_rs2_addr, wb_rd_addr;
    logic [XLEN-1:0] ex_rs1_v, ex_rs2_v, mem_alu_result, mem_rs2_v, wb_data;

    logic [XLEN-1:0] o1_rs1, o1_rs2, o1_mw, o3_rs1, o3_rs2, o3_mw;
    logic            o1_stall, o1_bubble, o3_stall, o3_bubble;
    logic [CW1-1:0]  o1_scnt, o1_fcnt;
    logic [CW3-1:0]  o3_scnt, o3_fcnt;

    hazard_forward_unit #(.XLEN(XLEN), .AW(AW), .LOAD_LAT(1), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_memwrite(id_memwrite), .flush(flush),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rs1_v(ex_rs1_v),
        .ex_rs2_v(ex_rs2_v), .ex_rd_addr(ex_rd_addr), .ex_memread(ex_memread),
        .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result),
        .mem_rs2_addr(mem_rs2_addr), .mem_rs2_v(mem_rs2_v), .wb_regwrite(wb_regwrite),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .fwd_rs1(o1_rs1), .fwd_rs2(o1_rs2),
        .fwd_m_wdata(o1_mw), .stall_if_id(o1_stall), .bubble_ex(o1_bubble),
        .stall_cnt(o1_scnt), .fwd_cnt(o1_fcnt));

    hazard_forward_unit #(.XLEN(XLEN), .AW(AW), .LOAD_LAT(3), .CNT_W(CW3)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_memwrite(id_memwrite), .flush(flush),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rs1_v(ex_rs1_v),
        .ex_rs2_v(ex_rs2_v), .ex_rd_addr(ex_rd_addr), .ex_memread(ex_memread),
        .mem_regwrite(mem_regwrite), .mem_rd_addr(mem_rd_addr), .mem_alu_result(mem_alu_result),
        .mem_rs2_addr(mem_rs2_addr), .mem_rs2_v(mem_rs2_v), .wb_regwrite(wb_regwrite),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .fwd_rs1(o3_rs1), .fwd_rs2(o3_rs2),
        .fwd_m_wdata(o3_mw), .stall_if_id(o3_stall), .bubble_ex(o3_bubble),
        .stall_cnt(o3_scnt), .fwd_cnt(o3_fcnt));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_in();
        id_valid = 0; id_memwrite = 0; flush = 0; ex_memread = 0;
        mem_regwrite = 0; wb_regwrite = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; ex_rs1_addr = 0; ex_rs2_addr = 0; ex_rd_addr = 0;
        mem_rd_addr = 0; mem_rs2_addr = 0; wb_rd_addr = 0;
        ex_rs1_v = 0; ex_rs2_v = 0; mem_alu_result = 0; mem_rs2_v = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_in();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic load_use(input logic [AW-1:0] rd);
        id_valid = 1; id_rs1_addr = rd; id_rs2_addr = 5'd3;
        ex_memread = 1; ex_rd_addr = rd;
    endtask

    // Youngest in-flight writer of a register wins; x0 always reads the register-file value.
    function automatic logic [XLEN-1:0] ref_src(input logic [AW-1:0] a, input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] v = rf;
        if (a == 0) return rf;
        if (wb_regwrite && wb_rd_addr == a) v = wb_data;
        if (mem_regwrite && mem_rd_addr == a) v = mem_alu_result;
        return v;
    endfunction

    function automatic int ref_fwd(input logic [AW-1:0] a);
        if (a == 0) return 0;
        return ((mem_regwrite && mem_rd_addr == a) || (wb_regwrite && wb_rd_addr == a)) ? 1 : 0;
    endfunction

    typedef struct {
        logic [AW-1:0] rs1, rs2; logic [XLEN-1:0] v1, v2;
        logic mrw; logic [AW-1:0] mrd; logic [XLEN-1:0] malu; logic [AW-1:0] mrs2; logic [XLEN-1:0] mv2;
        logic wrw; logic [AW-1:0] wrd; logic [XLEN-1:0] wd;
        logic [XLEN-1:0] e1, e2, em;
    } vec_t;

    vec_t vt[6];

    initial begin
        int rem1, rem3;
        longint sc1, fc1, sc3, fc3;
        logic hz_m, st1, st3;
        int nf;

        vt[0] = '{5'd5, 5'd3, 32'h1, 32'h2, 1'b1, 5'd5, 32'hAAAA, 5'd0, 32'h77, 1'b1, 5'd5, 32'h1111, 32'hAAAA, 32'h2, 32'h77};
        vt[1] = '{5'd1, 5'd0, 32'h10, 32'h0, 1'b0, 5'd0, 32'h5, 5'd0, 32'h33, 1'b1, 5'd0, 32'hFFFF, 32'h10, 32'h0, 32'h33};
        vt[2] = '{5'd4, 5'd4, 32'h1, 32'h2, 1'b0, 5'd4, 32'h9, 5'd4, 32'h3, 1'b1, 5'd4, 32'hBEEF, 32'hBEEF, 32'hBEEF, 32'hBEEF};
        vt[3] = '{5'd6, 5'd9, 32'h61, 32'h92, 1'b1, 5'd9, 32'h900, 5'd6, 32'h66, 1'b0, 5'd6, 32'hDEAD, 32'h61, 32'h900, 32'h66};
        vt[4] = '{5'd0, 5'd2, 32'h5, 32'h7, 1'b1, 5'd0, 32'hBAD, 5'd2, 32'h8, 1'b1, 5'd2, 32'h2222, 32'h5, 32'h2222, 32'h2222};
        vt[5] = '{5'd10, 5'd11, 32'h1, 32'h2, 1'b1, 5'd11, 32'hB0, 5'd10, 32'h10, 1'b1, 5'd10, 32'hA0, 32'hA0, 32'hB0, 32'hA0};

        rst_n = 0;
        clear_in();
        #1;
        chk("rst_stall1", o1_stall, 0);
        chk("rst_bubble1", o1_bubble, 0);
        chk("rst_stall3", o3_stall, 0);
        chk("rst_scnt1", o1_scnt, 0);
        chk("rst_fcnt1", o1_fcnt, 0);
        chk("rst_scnt3", o3_scnt, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vt[i]) begin
            @(negedge clk);
            ex_rs1_addr = vt[i].rs1; ex_rs2_addr = vt[i].rs2; ex_rs1_v = vt[i].v1; ex_rs2_v = vt[i].v2;
            mem_regwrite = vt[i].mrw; mem_rd_addr = vt[i].mrd; mem_alu_result = vt[i].malu;
            mem_rs2_addr = vt[i].mrs2; mem_rs2_v = vt[i].mv2;
            wb_regwrite = vt[i].wrw; wb_rd_addr = vt[i].wrd; wb_data = vt[i].wd;
            #1;
            chk($sformatf("vec%0d_rs1", i), o1_rs1, vt[i].e1);
            chk($sformatf("vec%0d_rs2", i), o1_rs2, vt[i].e2);
            chk($sformatf("vec%0d_mw", i), o1_mw, vt[i].em);
            chk($sformatf("vec%0d_rs1_l3", i), o3_rs1, vt[i].e1);
        end

        // Load rd=7 in EX, consumer rs1=7 in ID.
        do_reset();
        @(negedge clk); load_use(5'd7); #1;
        chk("lu_c0_stall1", o1_stall, 1);
        chk("lu_c0_bubble1", o1_bubble, 1);
        chk("lu_c0_stall3", o3_stall, 1);
        chk("lu_c0_bubble3", o3_bubble, 1);
        @(negedge clk); ex_memread = 0; ex_rd_addr = 0; #1;
        chk("lu_c1_stall1", o1_stall, 0);
        chk("lu_c1_stall3", o3_stall, 1);
        @(negedge clk); ex_rs1_addr = 5'd7; ex_rs1_v = 0; wb_regwrite = 1; wb_rd_addr = 5'd7; wb_data = 32'h1234; #1;
        chk("lu_c2_fwd_wb", o1_rs1, 32'h1234);
        chk("lu_c2_stall3", o3_stall, 1);
        @(negedge clk); wb_regwrite = 0; #1;
        chk("lu_c3_stall3", o3_stall, 0);
        chk("lu_scnt1", o1_scnt, PERF ? 1 : 0);
        chk("lu_scnt3", o3_scnt, PERF ? 3 : 0);
        chk("lu_fcnt1", o1_fcnt, PERF ? 1 : 0);

        // Flush during the LOAD_LAT=3 stall.
        do_reset();
        @(negedge clk); load_use(5'd7); #1;
        chk("fl_c0_stall3", o3_stall, 1);
        @(negedge clk); ex_memread = 0; ex_rd_addr = 0; flush = 1; #1;
        chk("fl_c1_stall3", o3_stall, 0);
        chk("fl_c1_bubble3", o3_bubble, 0);
        @(negedge clk); flush = 0; #1;
        chk("fl_c2_idle3", o3_stall, 0);
        chk("fl_scnt3", o3_scnt, PERF ? 1 : 0);

        // Load then store: data-only dependency needs no stall, address dependency does.
        @(negedge clk); clear_in();
        id_valid = 1; id_memwrite = 1; id_rs1_addr = 5'd2; id_rs2_addr = 5'd8;
        ex_memread = 1; ex_rd_addr = 5'd8; #1;
        chk("st_data_stall1", o1_stall, 0);
        chk("st_data_stall3", o3_stall, 0);
        id_rs1_addr = 5'd8; #1;
        chk("st_addr_stall3", o3_stall, 1);
        id_rs1_addr = 5'd2; id_valid = 0; id_memwrite = 0; id_rs2_addr = 5'd8; #1;
        chk("invalid_id_stall1", o1_stall, 0);
        @(negedge clk); clear_in(); flush = 1;
        mem_rs2_addr = 5'd8; mem_rs2_v = 32'h1; wb_regwrite = 1; wb_rd_addr = 5'd8; wb_data = 32'hCAFE; #1;
        chk("memmem_wdata", o1_mw, 32'hCAFE);

        // Reset asserted mid-stall.
        do_reset();
        @(negedge clk); load_use(5'd9); #1;
        @(negedge clk); #1;
        chk("rs_pre_stall3", o3_stall, 1);
        rst_n = 0; #1;
        chk("rs_stall3", o3_stall, 0);
        chk("rs_bubble3", o3_bubble, 0);
        chk("rs_stall1", o1_stall, 0);
        chk("rs_scnt3", o3_scnt, 0);
        @(negedge clk); clear_in(); rst_n = 1; #1;
        chk("rs_rel_scnt3", o3_scnt, 0);
        chk("rs_rel_scnt1", o1_scnt, 0);
        @(negedge clk); #1;
        chk("rs_idle3", o3_stall, 0);

        // Random traffic against the reference model.
        do_reset();
        rem1 = 0; rem3 = 0; sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            id_valid = ($urandom_range(0, 3) != 0);
            id_memwrite = $urandom_range(0, 1);
            flush = ($urandom_range(0, 7) == 0);
            ex_memread = $urandom_range(0, 1);
            mem_regwrite = $urandom_range(0, 1);
            wb_regwrite = $urandom_range(0, 1);
            id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
            ex_rs1_addr = 5'($urandom_range(0, 3)); ex_rs2_addr = 5'($urandom_range(0, 3));
            ex_rd_addr = 5'($urandom_range(0, 3)); mem_rd_addr = 5'($urandom_range(0, 3));
            mem_rs2_addr = 5'($urandom_range(0, 3)); wb_rd_addr = 5'($urandom_range(0, 3));
            ex_rs1_v = $urandom; ex_rs2_v = $urandom; mem_alu_result = $urandom;
            mem_rs2_v = $urandom; wb_data = $urandom;
            #1;
            hz_m = id_valid && ex_memread && ex_rd_addr != 0 &&
                   (ex_rd_addr == id_rs1_addr || (ex_rd_addr == id_rs2_addr && !id_memwrite));
            st1 = flush ? 1'b0 : (rem1 > 0 ? 1'b1 : hz_m);
            st3 = flush ? 1'b0 : (rem3 > 0 ? 1'b1 : hz_m);
            nf = ref_fwd(ex_rs1_addr) + ref_fwd(ex_rs2_addr);
            chk("rnd_rs1", o1_rs1, ref_src(ex_rs1_addr, ex_rs1_v));
            chk("rnd_rs2", o3_rs2, ref_src(ex_rs2_addr, ex_rs2_v));
            chk("rnd_mw", o1_mw, (wb_regwrite && mem_rs2_addr != 0 && wb_rd_addr == mem_rs2_addr) ? wb_data : mem_rs2_v);
            chk("rnd_stall1", o1_stall, st1);
            chk("rnd_bubble3", o3_bubble, st3);
            chk("rnd_scnt1", o1_scnt, PERF ? sc1 : 0);
            chk("rnd_fcnt1", o1_fcnt, PERF ? fc1 : 0);
            chk("rnd_scnt3", o3_scnt, PERF ? sc3 : 0);
            chk("rnd_fcnt3", o3_fcnt, PERF ? fc3 : 0);
            if (flush) rem1 = 0; else if (rem1 > 0) rem1--; else if (hz_m) rem1 = 0;
            if (flush) rem3 = 0; else if (rem3 > 0) rem3--; else if (hz_m) rem3 = 2;
            sc1 = (sc1 + st1 > 15) ? 15 : sc1 + st1;
            fc1 = (fc1 + nf > 15) ? 15 : fc1 + nf;
            sc3 = sc3 + st3;
            fc3 = fc3 + nf;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
